wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Write-back stage and register file; consumes the MEM/WB pipeline register outputs.
//  Selects write-back data (load data or ALU address result) and commits it to a 32-entry GPR file.
//  Provides two decode-stage read ports with same-cycle write->read bypass, so a load-use stall needs only one bubble.
//  Keeps a retired-instruction counter and the last retired instruction word for debug/trace.
// PARAMETERS
//  DATA_W   32  GPR / data width
//  ADDR_W   5   register index width (2**ADDR_W registers)
//  CNT_W    32  retire counter width
// PORTS
//  clock            in   1       system clock; all state updates on rising edge
//  reset            in   1       synchronous, active-high
//  MemToReg_wb      in   1       1: write back memReadData_wb, 0: write back memAddr_wb
//  RegWrite_wb      in   1       write-back enable
//  memReadData_wb   in   DATA_W  load data from MEM/WB
//  memAddr_wb       in   DATA_W  ALU result / address from MEM/WB
//  regWriteDst_wb   in   ADDR_W  destination register
//  id_wb            in   32      instruction word carried down the pipe (0 = bubble)
//  rs_addr          in   ADDR_W  read port A index
//  rt_addr          in   ADDR_W  read port B index
//  rs_data          out  DATA_W  read port A data (combinational)
//  rt_data          out  DATA_W  read port B data (combinational)
//  wb_data          out  DATA_W  selected write-back value (combinational, for forwarding)
//  wb_we            out  1       effective write enable (RegWrite_wb && regWriteDst_wb != 0)
//  retire_count     out  CNT_W   number of non-bubble instructions retired
//  last_id          out  32      most recent non-bubble id_wb retired
// BEHAVIOUR
//  - wb_data = MemToReg_wb ? memReadData_wb : memAddr_wb; pure mux, no latency.
//  - wb_we = RegWrite_wb && (regWriteDst_wb != 0); register 0 is never written and always reads 0.
//  - Commit: at the rising edge with wb_we=1, gpr[regWriteDst_wb] <= wb_data. Zero-latency commit; the new value
//    is visible in storage the following cycle.
//  - Read ports: rX_data = 0 if rX_addr==0; else wb_data if wb_we && rX_addr==regWriteDst_wb (bypass);
//    else gpr[rX_addr]. Both ports may hit the bypass in the same cycle.
//  - Retire: at the rising edge with id_wb != 0, retire_count <= retire_count+1 (wraps modulo 2**CNT_W)
//    and last_id <= id_wb. This is independent of RegWrite_wb (stores/branches retire too).
//    With id_wb == 0 both hold.
//  - Reset (synchronous, at rising edge with reset=1): all gpr <= 0, retire_count <= 0, last_id <= 0.
//    Reset dominates a simultaneous write or retire. During reset the read ports still obey the bypass
//    rule combinationally; storage is zero after the edge.
//  - Reset asserted mid-stream: the in-flight write-back in that cycle is discarded. No partial state survives.
//  - Inputs are sampled as presented by MEM/WB. No internal pipelining; no handshake; no stall input
//    (bubbles arrive as RegWrite_wb=0, id_wb=0).
//  - X-safety: with RegWrite_wb=0, an X on regWriteDst_wb must not corrupt storage.
// TESTING
//  1 reset, then read r1..r31 -> all 0; retire_count=0, last_id=0.
//  2 RegWrite=1, MemToReg=0, memAddr=0x0000_00AA, dst=5, id=0x2005_00AA; same cycle rs_addr=5
//    -> rs_data=0xAA (bypass); next cycle rs_data=0xAA from storage, retire_count=1, last_id=0x2005_00AA.
//  3 RegWrite=1, MemToReg=1, memReadData=0xDEAD_BEEF, memAddr=0x100, dst=9, rs=rt=9
//    -> rs_data=rt_data=wb_data=0xDEADBEEF; next cycle gpr[9]=0xDEADBEEF.
//  4 RegWrite=1, dst=0, memAddr=0xFFFF_FFFF, rs_addr=0 -> rs_data=0, wb_we=0; r0 still 0 afterwards.
//  5 bubble (id=0, RegWrite=0) for 3 cycles -> retire_count, last_id and all gpr unchanged.
//    Store (id=0xAC00_0004, RegWrite=0) -> retire_count+1, no gpr change.
//  6 write dst=3 value 7 while reset=1 -> gpr[3]=0 after the edge, retire_count=0.
//    Preload retire_count=2**CNT_W-1 (force), retire one more -> retire_count wraps to 0.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back stage: selects load/ALU result and commits it to a 32-entry GPR file.
// Two bypassed decode read ports, plus a retire counter and last-retired instruction word for trace.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              MemToReg_wb,
    input  logic              RegWrite_wb,
    input  logic [DATA_W-1:0] memReadData_wb,
    input  logic [DATA_W-1:0] memAddr_wb,
    input  logic [ADDR_W-1:0] regWriteDst_wb,
    input  logic [31:0]       id_wb,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we,
    output logic [CNT_W-1:0]  retire_count,
    output logic [31:0]       last_id
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] gpr_q [NREG];
    logic [CNT_W-1:0]  retire_count_q, retire_count_d;
    logic [31:0]       last_id_q, last_id_d;
    logic              retire;

    assign wb_data = MemToReg_wb ? memReadData_wb : memAddr_wb;
    // RegWrite_wb gates first so an unknown destination during a bubble cannot enable a write.
    assign wb_we   = RegWrite_wb && (regWriteDst_wb != '0);
    assign retire  = (id_wb != 32'd0);

    always_comb begin
        retire_count_d = retire_count_q;
        last_id_d      = last_id_q;
        if (retire) begin
            retire_count_d = retire_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            last_id_d      = id_wb;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                gpr_q[i] <= '0;
            end
            retire_count_q <= '0;
            last_id_q      <= '0;
        end else begin
            if (wb_we) begin
                gpr_q[regWriteDst_wb] <= wb_data;
            end
            retire_count_q <= retire_count_d;
            last_id_q      <= last_id_d;
        end
    end

    // Same-cycle bypass lets a dependent decode see the value being committed this edge.
    always_comb begin
        rs_data = gpr_q[rs_addr];
        if (rs_addr == '0) begin
            rs_data = '0;
        end else if (wb_we && (rs_addr == regWriteDst_wb)) begin
            rs_data = wb_data;
        end
    end

    always_comb begin
        rt_data = gpr_q[rt_addr];
        if (rt_addr == '0) begin
            rt_data = '0;
        end else if (wb_we && (rt_addr == regWriteDst_wb)) begin
            rt_data = wb_data;
        end
    end

    assign retire_count = retire_count_q;
    assign last_id      = last_id_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: expectations are queued as stimulus is applied and popped when sampled.
// A second instance with a 4-bit retire counter shares the stimulus to exercise counter wrap.
module tb_wb_regfile;

    logic        clock = 1'b0;
    logic        reset;
    logic        MemToReg_wb;
    logic        RegWrite_wb;
    logic [31:0] memReadData_wb;
    logic [31:0] memAddr_wb;
    logic [4:0]  regWriteDst_wb;
    logic [31:0] id_wb;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data, rt_data, wb_data;
    logic        wb_we;
    logic [31:0] retire_count;
    logic [31:0] last_id;

    logic [31:0] s_rs_data, s_rt_data, s_wb_data, s_last_id;
    logic        s_wb_we;
    logic [3:0]  s_retire_count;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   failed = 0;

    always #5 clock = ~clock;

    wb_regfile dut (
        .clock(clock), .reset(reset), .MemToReg_wb(MemToReg_wb), .RegWrite_wb(RegWrite_wb),
        .memReadData_wb(memReadData_wb), .memAddr_wb(memAddr_wb), .regWriteDst_wb(regWriteDst_wb),
        .id_wb(id_wb), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .wb_data(wb_data), .wb_we(wb_we), .retire_count(retire_count), .last_id(last_id)
    );

    wb_regfile #(.CNT_W(4)) dut_small (
        .clock(clock), .reset(reset), .MemToReg_wb(MemToReg_wb), .RegWrite_wb(RegWrite_wb),
        .memReadData_wb(memReadData_wb), .memAddr_wb(memAddr_wb), .regWriteDst_wb(regWriteDst_wb),
        .id_wb(id_wb), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(s_rs_data), .rt_data(s_rt_data),
        .wb_data(s_wb_data), .wb_we(s_wb_we), .retire_count(s_retire_count), .last_id(s_last_id)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            failed++;
            $error("FAIL %s scoreboard empty, observed %h", tag, obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp && tag == e.tag)
            else begin
                failed++;
                $error("FAIL %s observed %h expected %h (queued tag %s)", tag, obs, e.exp, e.tag);
            end
        end
    endtask

    task automatic bubble();
        RegWrite_wb    = 1'b0;
        MemToReg_wb    = 1'b0;
        id_wb          = 32'd0;
        regWriteDst_wb = 5'd0;
        memAddr_wb     = 32'd0;
        memReadData_wb = 32'd0;
    endtask

    task automatic read_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
        rs_addr = r;
        rt_addr = r;
        expect_val({tag, "_rs"}, exp);
        expect_val({tag, "_rt"}, exp);
        #1;
        chk({tag, "_rs"}, rs_data);
        chk({tag, "_rt"}, rt_data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bubble();
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        tick();
        tick();
        reset = 1'b0;

        // 1: everything zero after reset
        for (int r = 1; r < 32; r++) begin
            read_reg("rst_gpr", 5'(r), 32'd0);
        end
        expect_val("rst_cnt", 32'd0);
        expect_val("rst_last", 32'd0);
        chk("rst_cnt", retire_count);
        chk("rst_last", last_id);

        // 2: ALU result write with same-cycle bypass
        RegWrite_wb = 1'b1; MemToReg_wb = 1'b0; memAddr_wb = 32'h0000_00AA;
        memReadData_wb = 32'h5555_5555; regWriteDst_wb = 5'd5; id_wb = 32'h2005_00AA; rs_addr = 5'd5;
        expect_val("t2_bypass", 32'h0000_00AA);
        expect_val("t2_we", 32'd1);
        #1;
        chk("t2_bypass", rs_data);
        chk("t2_we", {31'd0, wb_we});
        tick();
        bubble();
        read_reg("t2_store", 5'd5, 32'h0000_00AA);
        expect_val("t2_cnt", 32'd1);
        expect_val("t2_last", 32'h2005_00AA);
        chk("t2_cnt", retire_count);
        chk("t2_last", last_id);

        // 3: load data selected, both ports bypass
        RegWrite_wb = 1'b1; MemToReg_wb = 1'b1; memReadData_wb = 32'hDEAD_BEEF;
        memAddr_wb = 32'h0000_0100; regWriteDst_wb = 5'd9; id_wb = 32'h8C09_0100;
        rs_addr = 5'd9; rt_addr = 5'd9;
        expect_val("t3_rs", 32'hDEAD_BEEF);
        expect_val("t3_rt", 32'hDEAD_BEEF);
        expect_val("t3_wbd", 32'hDEAD_BEEF);
        #1;
        chk("t3_rs", rs_data);
        chk("t3_rt", rt_data);
        chk("t3_wbd", wb_data);
        tick();
        bubble();
        read_reg("t3_store", 5'd9, 32'hDEAD_BEEF);
        read_reg("t3_r5", 5'd5, 32'h0000_00AA);

        // 4: writes to r0 are suppressed
        RegWrite_wb = 1'b1; MemToReg_wb = 1'b0; memAddr_wb = 32'hFFFF_FFFF;
        regWriteDst_wb = 5'd0; id_wb = 32'h2000_FFFF; rs_addr = 5'd0; rt_addr = 5'd9;
        expect_val("t4_r0", 32'd0);
        expect_val("t4_we", 32'd0);
        expect_val("t4_wbd", 32'hFFFF_FFFF);
        #1;
        chk("t4_r0", rs_data);
        chk("t4_we", {31'd0, wb_we});
        chk("t4_wbd", wb_data);
        tick();
        bubble();
        read_reg("t4_r0_after", 5'd0, 32'd0);
        expect_val("t4_cnt", 32'd3);
        chk("t4_cnt", retire_count);

        // 5: bubbles hold state even with an unknown destination; a store still retires
        RegWrite_wb = 1'b0; id_wb = 32'd0; regWriteDst_wb = 'x; memAddr_wb = 32'h1234_5678;
        tick(); tick(); tick();
        bubble();
        expect_val("t5_cnt", 32'd3);
        expect_val("t5_last", 32'h2000_FFFF);
        chk("t5_cnt", retire_count);
        chk("t5_last", last_id);
        read_reg("t5_r5", 5'd5, 32'h0000_00AA);
        read_reg("t5_r9", 5'd9, 32'hDEAD_BEEF);
        RegWrite_wb = 1'b0; id_wb = 32'hAC00_0004; regWriteDst_wb = 5'd5; memAddr_wb = 32'h0000_0004;
        tick();
        bubble();
        expect_val("t5_st_cnt", 32'd4);
        expect_val("t5_st_last", 32'hAC00_0004);
        chk("t5_st_cnt", retire_count);
        chk("t5_st_last", last_id);
        read_reg("t5_st_r5", 5'd5, 32'h0000_00AA);

        // 6: reset dominates an in-flight write and retire; bypass still visible during reset
        reset = 1'b1; RegWrite_wb = 1'b1; MemToReg_wb = 1'b0; memAddr_wb = 32'd7;
        regWriteDst_wb = 5'd3; id_wb = 32'h2003_0007; rs_addr = 5'd3;
        expect_val("t6_rst_bypass", 32'd7);
        #1;
        chk("t6_rst_bypass", rs_data);
        tick();
        reset = 1'b0;
        bubble();
        read_reg("t6_r3", 5'd3, 32'd0);
        read_reg("t6_r5", 5'd5, 32'd0);
        read_reg("t6_r9", 5'd9, 32'd0);
        expect_val("t6_cnt", 32'd0);
        expect_val("t6_last", 32'd0);
        chk("t6_cnt", retire_count);
        chk("t6_last", last_id);

        // Counter wrap on the 4-bit instance: 15 retires reach max, the 16th wraps to 0
        for (int k = 1; k <= 15; k++) begin
            id_wb = 32'h1000_0000 + 32'(k);
            tick();
        end
        bubble();
        expect_val("wrap_max", 32'd15);
        expect_val("wrap_main", 32'd15);
        chk("wrap_max", {28'd0, s_retire_count});
        chk("wrap_main", retire_count);
        id_wb = 32'h1000_0010;
        tick();
        bubble();
        expect_val("wrap_zero", 32'd0);
        expect_val("wrap_main16", 32'd16);
        expect_val("wrap_last", 32'h1000_0010);
        chk("wrap_zero", {28'd0, s_retire_count});
        chk("wrap_main16", retire_count);
        chk("wrap_last", s_last_id);

        if (sb.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL scoreboard_leftover observed %0d entries expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
